// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared sizing constants and reader FSM state encoding for
//               the FIFO block and its burst reader.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int BIT   = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_rd_skid.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_skid
// Description : Two-entry output buffer between the FIFO read port and the
//               downstream valid/ready interface. Captures returned read
//               data, pops on transfer, exposes occupancy and head word.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occupancy,
  output logic             valid,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             pop_ok;

  // A pop only takes effect when a word is actually held.
  assign pop_ok = pop & (occ_q != 2'd0);

  // Next-state for storage, pointers and occupancy; push and pop may coincide
  // and then occupancy is unchanged while the two pointers both advance.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    occ_d = occ_q + {1'b0, push} - {1'b0, pop_ok};
  end

  // State registers; clearing storage keeps head_data at zero in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign occupancy = occ_q;
  assign valid     = (occ_q != 2'd0);
  assign head_data = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_reader
// Description : Burst reader. On start, issues up to len reads to a FIFO with
//               one-cycle read latency and forwards the words downstream over
//               a valid/ready interface through a two-entry buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_reader #(
  parameter int WIDTH = fifo_pkg::WIDTH,
  parameter int DEPTH = fifo_pkg::DEPTH,
  parameter int BIT   = fifo_pkg::BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIT:0]     len,
  input  logic             fifoempty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             re,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic [BIT:0]     count
);

  import fifo_pkg::*;

  localparam logic [BIT:0] MAX_LEN = (BIT+1)'(DEPTH);

  rd_state_t    state_q, state_d;
  logic [BIT:0] len_q, len_d;
  logic [BIT:0] issued_q, issued_d;
  logic [BIT:0] count_q, count_d;
  logic         inflight_q, inflight_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [BIT:0] len_eff;
  logic [1:0]   occ;
  logic [1:0]   occ_after_pop;
  logic         xfer;

  // Requests beyond the attached FIFO depth are clamped to a full burst.
  assign len_eff = (len > MAX_LEN) ? MAX_LEN : len;

  assign xfer          = m_valid & m_ready;
  // Counting this cycle's pop as already freed lets a read issue into the
  // slot being vacated, which is what sustains one word per cycle.
  assign occ_after_pop = occ - {1'b0, xfer};

  // Read enable: only while running, FIFO has data, burst not fully issued,
  // and the buffer can absorb the word once it returns.
  assign re = (state_q == ST_RUN) && !fifoempty && (issued_q < len_q) &&
              ((occ_after_pop + {1'b0, inflight_q}) < 2'd2);

  fifo_rd_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (fifo_dout),
    .pop       (xfer),
    .occupancy (occ),
    .valid     (m_valid),
    .head_data (m_data)
  );

  // FSM transitions, burst counters and next values of the status outputs.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    count_d    = count_q;
    inflight_d = re;
    if (xfer) begin
      count_d = count_q + (BIT+1)'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d    = len_eff;
          issued_d = '0;
          count_d  = '0;
          state_d  = (len_eff == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (re) begin
          issued_d = issued_q + (BIT+1)'(1);
        end
        if (issued_d == len_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && (occ == 2'd0)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Single state register for the FSM, counters and registered status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_reader
// Description : Self-checking bench for fifo_reader. A queue-based FIFO with
//               one-cycle read latency feeds the reader; delivered words are
//               compared with the words written, in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int BIT   = 4;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             start     = 1'b0;
  logic [BIT:0]     len       = '0;
  logic             fifoempty = 1'b1;
  logic [WIDTH-1:0] fifo_dout = '0;
  logic             m_ready   = 1'b0;
  logic             re;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             busy;
  logic             done;
  logic [BIT:0]     count;

  int tests = 0;
  int fails = 0;

  fifo_reader #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .BIT   (BIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .fifoempty (fifoempty),
    .fifo_dout (fifo_dout),
    .re        (re),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bench FIFO: words requested by the stimulus land at the next edge.
  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] wr_pend[$];
  int               flush_cnt  = 0;
  int               flush_seen = 0;

  always @(posedge clk) begin
    if (re) begin
      chk("no_underflow", 32'(fq.size() != 0), 32'd1);
      if (fq.size() != 0) fifo_dout <= fq.pop_front();
    end
    if (flush_cnt != flush_seen) begin
      fq.delete();
      flush_seen = flush_cnt;
    end
    while (wr_pend.size() != 0) fq.push_back(wr_pend.pop_front());
    fifoempty <= (fq.size() == 0);
  end

  // Monitor, mid-cycle: a transfer seen here completes at the next edge.
  int               cyc = 0;
  int               re_cnt = 0;
  int               done_cnt = 0;
  int               last_done_cyc = 0;
  logic [WIDTH-1:0] got[$];
  int               got_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        got_cyc.push_back(cyc);
      end
      if (re) re_cnt++;
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input int l);
    start = 1'b1;
    len   = l[BIT:0];
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string tag);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    step();
    step();
  endtask

  int               base, r0, d0, c0, n, l, pushed;
  logic [WIDTH-1:0] bw [4];
  logic [WIDTH-1:0] exp_q[$];

  initial begin
    // ---------------- reset state, asynchronous --------------------------
    #2 rst = 1'b0;
    #1;
    chk("rst_re", 32'(re), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(count), 0);
    step();
    step();
    rst = 1'b1;
    step();

    // ---------------- steady drain, len=16 -------------------------------
    for (int i = 0; i < 16; i++) wr_pend.push_back(8'(i));
    m_ready = 1'b1;
    step();
    base = got.size(); r0 = re_cnt; d0 = done_cnt; c0 = cyc;
    kick(16);
    chk("a_busy", 32'(busy), 1);
    wait_done(d0, 80, "a");
    chk("a_nxfer", 32'(got.size() - base), 16);
    for (int i = 0; i < 16; i++)
      if (base + i < got.size()) chk("a_word", 32'(got[base+i]), 32'(i));
    if (got.size() - base == 16) begin
      chk("a_latency", 32'(got_cyc[base] - c0), 4);
      chk("a_consec", 32'(got_cyc[base+15] - got_cyc[base]), 15);
    end
    chk("a_re_cnt", 32'(re_cnt - r0), 16);
    chk("a_done_cnt", 32'(done_cnt - d0), 1);
    chk("a_count", 32'(count), 16);
    chk("a_idle", 32'(busy), 0);

    // ---------------- backpressure, len=4 --------------------------------
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bw[i] = 8'($urandom);
      wr_pend.push_back(bw[i]);
    end
    step();
    base = got.size(); r0 = re_cnt; d0 = done_cnt;
    kick(4);
    for (int i = 0; i < 10; i++) begin
      step();
      if (m_valid) chk("b_hold_data", 32'(m_data), 32'(bw[0]));
    end
    chk("b_re_stall", 32'(re_cnt - r0), 2);
    chk("b_valid", 32'(m_valid), 1);
    m_ready = 1'b1;
    wait_done(d0, 60, "b");
    chk("b_nxfer", 32'(got.size() - base), 4);
    for (int i = 0; i < 4; i++)
      if (base + i < got.size()) chk("b_word", 32'(got[base+i]), 32'(bw[i]));
    chk("b_re_cnt", 32'(re_cnt - r0), 4);
    chk("b_count", 32'(count), 4);

    // ---------------- empty stall, len=3 ---------------------------------
    base = got.size(); r0 = re_cnt; d0 = done_cnt;
    kick(3);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 5; j++) step();
      bw[k] = 8'($urandom);
      wr_pend.push_back(bw[k]);
    end
    wait_done(d0, 60, "c");
    chk("c_nxfer", 32'(got.size() - base), 3);
    for (int i = 0; i < 3; i++)
      if (base + i < got.size()) chk("c_word", 32'(got[base+i]), 32'(bw[i]));
    if (got.size() - base == 3)
      chk("c_done_after", 32'(last_done_cyc > got_cyc[base+2]), 1);
    chk("c_count", 32'(count), 3);

    // ---------------- zero length ----------------------------------------
    r0 = re_cnt; d0 = done_cnt;
    kick(0);
    chk("d_done", 32'(done), 1);
    chk("d_busy", 32'(busy), 1);
    step();
    chk("d_done_low", 32'(done), 0);
    chk("d_busy_low", 32'(busy), 0);
    chk("d_re_cnt", 32'(re_cnt - r0), 0);
    chk("d_count", 32'(count), 0);

    // ---------------- start while busy -----------------------------------
    for (int i = 0; i < 6; i++) wr_pend.push_back(8'(8'h40 + i));
    step();
    base = got.size(); r0 = re_cnt; d0 = done_cnt;
    kick(5);
    step();
    start = 1'b1; len = 5'd2;
    step();
    start = 1'b0;
    wait_done(d0, 60, "e");
    chk("e_nxfer", 32'(got.size() - base), 5);
    chk("e_re_cnt", 32'(re_cnt - r0), 5);
    chk("e_count", 32'(count), 5);
    flush_cnt++;
    step();

    // ---------------- reset mid-burst ------------------------------------
    for (int i = 0; i < 8; i++) wr_pend.push_back(8'(8'h80 + i));
    step();
    base = got.size(); d0 = done_cnt;
    kick(8);
    n = 0;
    while (got.size() - base < 3 && n < 60) begin
      step();
      n++;
    end
    chk("f_three_xfer", 32'(got.size() - base), 3);
    rst = 1'b0;
    #1;
    chk("f_rst_re", 32'(re), 0);
    chk("f_rst_valid", 32'(m_valid), 0);
    chk("f_rst_data", 32'(m_data), 0);
    chk("f_rst_busy", 32'(busy), 0);
    chk("f_rst_done", 32'(done), 0);
    chk("f_rst_count", 32'(count), 0);
    step();
    step();
    rst = 1'b1;
    chk("f_no_done", 32'(done_cnt - d0), 0);
    flush_cnt++;
    bw[0] = 8'($urandom); bw[1] = 8'($urandom);
    wr_pend.push_back(bw[0]);
    wr_pend.push_back(bw[1]);
    step();
    base = got.size(); d0 = done_cnt;
    kick(2);
    wait_done(d0, 60, "f");
    chk("f_nxfer", 32'(got.size() - base), 2);
    for (int i = 0; i < 2; i++)
      if (base + i < got.size()) chk("f_word", 32'(got[base+i]), 32'(bw[i]));
    chk("f_count", 32'(count), 2);

    // ---------------- randomized bursts ----------------------------------
    for (int b = 0; b < 6; b++) begin
      l = $urandom_range(1, DEPTH);
      exp_q.delete();
      for (int i = 0; i < l; i++) exp_q.push_back(8'($urandom));
      pushed = 0;
      base = got.size(); r0 = re_cnt; d0 = done_cnt;
      kick(l);
      n = 0;
      while (done_cnt == d0 && n < 600) begin
        if (pushed < l && $urandom_range(0, 1) == 1) begin
          wr_pend.push_back(exp_q[pushed]);
          pushed++;
        end
        m_ready = ($urandom_range(0, 3) != 0);
        step();
        n++;
      end
      m_ready = 1'b1;
      chk("r_done_seen", 32'(done_cnt != d0), 1);
      step();
      chk("r_nxfer", 32'(got.size() - base), 32'(l));
      for (int i = 0; i < l; i++)
        if (base + i < got.size()) chk("r_word", 32'(got[base+i]), 32'(exp_q[i]));
      chk("r_re_cnt", 32'(re_cnt - r0), 32'(l));
      chk("r_done_cnt", 32'(done_cnt - d0), 1);
      chk("r_count", 32'(count), 32'(l));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
